// File: rtl/gamma_metric_buffer.sv
// gamma_metric_buffer
//   Branch-metric (gamma) store for the MAP decoder. Buffers one trellis
//   window of DEPTH steps, NCH signed W-bit metrics per step, written in
//   trellis order. The window is then replayed as a burst, either ascending
//   (for the alpha recursion) or descending (for the beta recursion). It can
//   optionally be held so that the same window is read twice.
//
// Ports
//   clk          clock, all logic on the rising edge
//   rst          synchronous active-high reset
//   wr_en_i      write one trellis step (accepted only while filling)
//   wr_data_i    NCH*W step metrics, channel k at [k*W +: W]
//   rd_start_i   request a burst readout (accepted only when full)
//   rd_dir_i     sampled with rd_start_i: 0 ascending, 1 descending
//   rd_hold_i    sampled with rd_start_i: 1 keep window, 0 release it
//   rd_data_o    registered read data, holds when rd_valid_o is low
//   rd_valid_o   rd_data_o carries a window entry this cycle
//   rd_last_o    final entry of the burst
//   w_done_o     level, window is full
//   r_done_o     one-cycle pulse with rd_last_o
//   wr_ovf_o     one-cycle pulse, a write was rejected
//   wr_count_o   entries currently written (0..DEPTH)

module gamma_metric_buffer #(
  parameter int W     = 16,
  parameter int DEPTH = 8,
  parameter int NCH   = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en_i,
  input  logic [NCH*W-1:0]   wr_data_i,
  input  logic               rd_start_i,
  input  logic               rd_dir_i,
  input  logic               rd_hold_i,
  output logic [NCH*W-1:0]   rd_data_o,
  output logic               rd_valid_o,
  output logic               rd_last_o,
  output logic               w_done_o,
  output logic               r_done_o,
  output logic               wr_ovf_o,
  output logic [AW:0]        wr_count_o
);

  localparam int CW = AW + 1;

  localparam logic [1:0] ST_FILL = 2'd0;
  localparam logic [1:0] ST_FULL = 2'd1;
  localparam logic [1:0] ST_READ = 2'd2;

  // Pointer bounds are explicit so a non-power-of-two DEPTH never wraps
  // through unused addresses.
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
  localparam logic [AW-1:0] PTR_ZERO = AW'(0);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [NCH*W-1:0] mem_q [DEPTH];

  logic [1:0]       state_q,    state_d;
  logic [AW-1:0]    wr_ptr_q,   wr_ptr_d;
  logic [CW-1:0]    wr_count_q, wr_count_d;
  logic [AW-1:0]    rd_ptr_q,   rd_ptr_d;
  logic [AW-1:0]    rd_cnt_q,   rd_cnt_d;
  logic             rd_dir_q,   rd_dir_d;
  logic             rd_hold_q,  rd_hold_d;
  logic [NCH*W-1:0] rd_data_q,  rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             rd_last_q,  rd_last_d;
  logic             r_done_q,   r_done_d;
  logic             w_done_q,   w_done_d;
  logic             wr_ovf_q,   wr_ovf_d;
  logic             mem_we_s;

  // Next-state logic for the FILL / FULL / READ controller and its outputs.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    wr_count_d = wr_count_q;
    rd_ptr_d   = rd_ptr_q;
    rd_cnt_d   = rd_cnt_q;
    rd_dir_d   = rd_dir_q;
    rd_hold_d  = rd_hold_q;
    rd_data_d  = rd_data_q;
    w_done_d   = w_done_q;
    rd_valid_d = 1'b0;
    rd_last_d  = 1'b0;
    r_done_d   = 1'b0;
    wr_ovf_d   = 1'b0;
    mem_we_s   = 1'b0;

    case (state_q)
      ST_FILL: begin
        // rd_start_i is ignored here, even alongside the final write.
        if (wr_en_i) begin
          mem_we_s   = 1'b1;
          wr_count_d = wr_count_q + CNT_ONE;
          if (wr_ptr_q == PTR_LAST) begin
            wr_ptr_d = PTR_ZERO;
            w_done_d = 1'b1;
            state_d  = ST_FULL;
          end else begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
          end
        end else begin
          wr_ptr_d = wr_ptr_q;
        end
      end

      ST_FULL: begin
        wr_ovf_d = wr_en_i;
        if (rd_start_i) begin
          rd_dir_d  = rd_dir_i;
          rd_hold_d = rd_hold_i;
          rd_ptr_d  = rd_dir_i ? PTR_LAST : PTR_ZERO;
          rd_cnt_d  = PTR_ZERO;
          state_d   = ST_READ;
        end else begin
          state_d = ST_FULL;
        end
      end

      ST_READ: begin
        wr_ovf_d   = wr_en_i;
        rd_data_d  = mem_q[rd_ptr_q];
        rd_valid_d = 1'b1;
        if (rd_cnt_q == PTR_LAST) begin
          // Final beat: pointer is left in range rather than stepped past.
          rd_last_d = 1'b1;
          r_done_d  = 1'b1;
          if (rd_hold_q) begin
            state_d = ST_FULL;
          end else begin
            state_d    = ST_FILL;
            w_done_d   = 1'b0;
            wr_ptr_d   = PTR_ZERO;
            wr_count_d = CNT_ZERO;
          end
        end else begin
          rd_cnt_d = rd_cnt_q + PTR_ONE;
          rd_ptr_d = rd_dir_q ? (rd_ptr_q - PTR_ONE) : (rd_ptr_q + PTR_ONE);
        end
      end

      default: begin
        state_d    = ST_FILL;
        wr_ptr_d   = PTR_ZERO;
        wr_count_d = CNT_ZERO;
        w_done_d   = 1'b0;
      end
    endcase
  end

  // Control and output registers; rd_data also clears on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_FILL;
      wr_ptr_q   <= PTR_ZERO;
      wr_count_q <= CNT_ZERO;
      rd_ptr_q   <= PTR_ZERO;
      rd_cnt_q   <= PTR_ZERO;
      rd_dir_q   <= 1'b0;
      rd_hold_q  <= 1'b0;
      rd_data_q  <= {(NCH*W){1'b0}};
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      r_done_q   <= 1'b0;
      w_done_q   <= 1'b0;
      wr_ovf_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      wr_count_q <= wr_count_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_cnt_q   <= rd_cnt_d;
      rd_dir_q   <= rd_dir_d;
      rd_hold_q  <= rd_hold_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      r_done_q   <= r_done_d;
      w_done_q   <= w_done_d;
      wr_ovf_q   <= wr_ovf_d;
    end
  end

  // Metric storage; deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign rd_last_o  = rd_last_q;
  assign r_done_o   = r_done_q;
  assign w_done_o   = w_done_q;
  assign wr_ovf_o   = wr_ovf_q;
  assign wr_count_o = wr_count_q;

endmodule

// File: tb/tb_gamma_metric_buffer.sv
// tb_gamma_metric_buffer
//   Directed bench for gamma_metric_buffer. A default instance (DEPTH 8,
//   NCH 4, W 16) is driven from a table of per-cycle records. A second
//   instance (DEPTH 5, NCH 2, W 12) is exercised with hand-written bursts.

module tb_gamma_metric_buffer;

  logic        clk = 1'b0;
  logic        rst;

  // Default instance signals.
  logic        wr_en, rd_start, rd_dir, rd_hold;
  logic [63:0] wr_data, rd_data;
  logic        rd_valid, rd_last, w_done, r_done, wr_ovf;
  logic [3:0]  wr_count;

  // Small instance signals.
  logic        b_rst, b_wr_en, b_rd_start, b_rd_dir, b_rd_hold;
  logic [23:0] b_wr_data, b_rd_data;
  logic        b_rd_valid, b_rd_last, b_w_done, b_r_done, b_wr_ovf;
  logic [3:0]  b_wr_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  gamma_metric_buffer #(.W(16), .DEPTH(8), .NCH(4)) dut (
    .clk(clk), .rst(rst),
    .wr_en_i(wr_en), .wr_data_i(wr_data),
    .rd_start_i(rd_start), .rd_dir_i(rd_dir), .rd_hold_i(rd_hold),
    .rd_data_o(rd_data), .rd_valid_o(rd_valid), .rd_last_o(rd_last),
    .w_done_o(w_done), .r_done_o(r_done), .wr_ovf_o(wr_ovf),
    .wr_count_o(wr_count)
  );

  gamma_metric_buffer #(.W(12), .DEPTH(5), .NCH(2)) dut_b (
    .clk(clk), .rst(b_rst),
    .wr_en_i(b_wr_en), .wr_data_i(b_wr_data),
    .rd_start_i(b_rd_start), .rd_dir_i(b_rd_dir), .rd_hold_i(b_rd_hold),
    .rd_data_o(b_rd_data), .rd_valid_o(b_rd_valid), .rd_last_o(b_rd_last),
    .w_done_o(b_w_done), .r_done_o(b_r_done), .wr_ovf_o(b_wr_ovf),
    .wr_count_o(b_wr_count)
  );

  typedef struct {
    logic        rst;
    logic        we;
    logic [63:0] wd;
    logic        rs;
    logic        rdir;
    logic        rhold;
    logic        e_valid;
    logic        e_last;
    logic        e_wdone;
    logic        e_ovf;
    logic [3:0]  e_cnt;
    logic [63:0] e_data;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [63:0] step_d(input int i);
    return {16'(i + 300), 16'(i + 200), 16'(i + 100), 16'(i)};
  endfunction

  // Negative metrics; step 0 channel 0 is -5 = 16'hFFFB.
  function automatic logic [63:0] neg_d(input int i);
    return {16'(-(i + 35)), 16'(-(i + 25)), 16'(-(i + 15)), 16'(-(i + 5))};
  endfunction

  function automatic logic [63:0] pick(input bit neg, input int i);
    return neg ? neg_d(i) : step_d(i);
  endfunction

  task automatic chk(input string nm, input int row, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row=%0d actual=%h expected=%h", nm, row, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic we, input logic [63:0] wd,
                     input logic rs, input logic rdir, input logic rhold,
                     input logic ev, input logic el, input logic ewd,
                     input logic eovf, input logic [3:0] ecnt,
                     input logic [63:0] ed);
    vec_t v;
    v.rst = r; v.we = we; v.wd = wd; v.rs = rs; v.rdir = rdir; v.rhold = rhold;
    v.e_valid = ev; v.e_last = el; v.e_wdone = ewd; v.e_ovf = eovf;
    v.e_cnt = ecnt; v.e_data = ed;
    tbl.push_back(v);
  endtask

  // Eight writes; optionally raise rd_start with the 4th and 8th write.
  task automatic add_fill(input bit neg, input bit rs_mid);
    for (int i = 0; i < 8; i++)
      add(1'b0, 1'b1, pick(neg, i), rs_mid && (i == 3 || i == 7), 1'b0, 1'b0,
          1'b0, 1'b0, (i == 7), 1'b0, 4'(i + 1), 64'h0);
  endtask

  task automatic add_start(input logic dir, input logic hold, input logic we);
    add(1'b0, we, 64'hDEAD_BEEF_CAFE_F00D, 1'b1, dir, hold,
        1'b0, 1'b0, 1'b1, we, 4'd8, 64'h0);
  endtask

  // Burst beats; ovf_row marks a beat with a (rejected) write attempt.
  task automatic add_burst(input bit neg, input logic dir, input logic hold,
                           input int ovf_row, input int nrows);
    for (int j = 0; j < nrows; j++) begin
      int  e;
      bit  fin;
      bit  keep;
      e    = dir ? 7 - j : j;
      fin  = (j == 7);
      keep = hold || !fin;
      add(1'b0, (j == ovf_row), 64'h1111_2222_3333_4444, 1'b0, 1'b0, 1'b0,
          1'b1, fin, keep, (j == ovf_row), keep ? 4'd8 : 4'd0, pick(neg, e));
    end
  endtask

  task automatic b_burst(input logic dir, input logic hold);
    int k;
    bit done;
    int e;
    b_rd_start = 1'b1; b_rd_dir = dir; b_rd_hold = hold;
    @(posedge clk); #1;
    b_rd_start = 1'b0; b_rd_dir = 1'b0; b_rd_hold = 1'b0;
    chk("b_valid_at_start", 0, 64'(b_rd_valid), 64'd0);
    k = 0; done = 1'b0;
    for (int c = 0; c < 12 && !done; c++) begin
      @(posedge clk); #1;
      if (b_rd_valid) begin
        e = dir ? 4 - k : k;
        chk("b_data", k, 64'(b_rd_data), {40'h0, 12'(e + 100), 12'(e)});
        chk("b_last", k, 64'(b_rd_last), 64'(k == 4));
        chk("b_r_done", k, 64'(b_r_done), 64'(k == 4));
        k++;
        if (b_rd_last) done = 1'b1;
      end
    end
    chk("b_beats", 0, 64'(k), 64'd5);
    chk("b_w_done_after", 0, 64'(b_w_done), hold ? 64'd1 : 64'd0);
    chk("b_count_after", 0, 64'(b_wr_count), hold ? 64'd5 : 64'd0);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_data = 64'h0;
    rd_start = 1'b0; rd_dir = 1'b0; rd_hold = 1'b0;
    b_rst = 1'b1; b_wr_en = 1'b0; b_wr_data = 24'h0;
    b_rd_start = 1'b0; b_rd_dir = 1'b0; b_rd_hold = 1'b0;

    // Scenario table for the default instance.
    add_fill(1'b0, 1'b1);
    add(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd8, 64'h0);
    add(1'b0, 1'b1, 64'hBAD0_BAD0_BAD0_BAD0, 1'b0, 1'b0, 1'b0,
        1'b0, 1'b0, 1'b1, 1'b1, 4'd8, 64'h0);
    add_start(1'b0, 1'b1, 1'b1);
    add_burst(1'b0, 1'b0, 1'b1, 2, 8);
    add_start(1'b1, 1'b0, 1'b0);
    add_burst(1'b0, 1'b1, 1'b0, -1, 8);
    add_fill(1'b1, 1'b0);
    add_start(1'b0, 1'b0, 1'b0);
    add_burst(1'b1, 1'b0, 1'b0, -1, 8);
    add_fill(1'b0, 1'b0);
    add_start(1'b0, 1'b0, 1'b0);
    add_burst(1'b0, 1'b0, 1'b0, -1, 3);
    add(1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 64'h0);
    for (int i = 0; i < 2; i++)
      add(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 64'h0);
    add_fill(1'b1, 1'b0);
    add_start(1'b1, 1'b0, 1'b0);
    add_burst(1'b1, 1'b1, 1'b0, -1, 8);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", -1, 64'(rd_valid), 64'd0);
    chk("reset_data", -1, rd_data, 64'd0);
    chk("reset_w_done", -1, 64'(w_done), 64'd0);
    chk("reset_count", -1, 64'(wr_count), 64'd0);
    chk("reset_ovf", -1, 64'(wr_ovf), 64'd0);
    chk("reset_b_data", -1, 64'(b_rd_data), 64'd0);
    chk("reset_b_count", -1, 64'(b_wr_count), 64'd0);
    b_rst = 1'b0;

    foreach (tbl[n]) begin
      rst = tbl[n].rst; wr_en = tbl[n].we; wr_data = tbl[n].wd;
      rd_start = tbl[n].rs; rd_dir = tbl[n].rdir; rd_hold = tbl[n].rhold;
      @(posedge clk); #1;
      chk("valid", n, 64'(rd_valid), 64'(tbl[n].e_valid));
      chk("last", n, 64'(rd_last), 64'(tbl[n].e_last));
      chk("r_done", n, 64'(r_done), 64'(tbl[n].e_last));
      chk("w_done", n, 64'(w_done), 64'(tbl[n].e_wdone));
      chk("wr_ovf", n, 64'(wr_ovf), 64'(tbl[n].e_ovf));
      chk("wr_count", n, 64'(wr_count), 64'(tbl[n].e_cnt));
      if (tbl[n].e_valid) chk("rd_data", n, rd_data, tbl[n].e_data);
    end
    rst = 1'b0; wr_en = 1'b0; rd_start = 1'b0;

    // Small instance: DEPTH 5 fill, held descending burst, then ascending.
    for (int i = 0; i < 5; i++) begin
      b_wr_en = 1'b1; b_wr_data = {12'(i + 100), 12'(i)};
      @(posedge clk); #1;
      chk("b_count_fill", i, 64'(b_wr_count), 64'(i + 1));
      chk("b_w_done_fill", i, 64'(b_w_done), 64'(i == 4));
    end
    b_wr_en = 1'b0;
    b_burst(1'b1, 1'b1);
    b_burst(1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
